// File: rtl/hex_frame_tx.sv
// Frame of N_WORDS words -> uppercase hex ASCII over 8N1 UART (SEP between words, CR end; LF too with HEX_FRAME_TX_LF_EN).
// Latency: start bit one clk after accept, done after C*10*CLK_DIV clks; one frame in flight, frame_valid ignored until frame_ready.
module hex_frame_tx #(
   parameter int         CLK_DIV   = 434,
   parameter int         WORD_BITS = 32,
   parameter int         N_WORDS   = 4,
   parameter logic [7:0] SEP_CHAR  = 8'h20
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [N_WORDS*WORD_BITS-1:0]   frame_data,
   input  logic                           frame_valid,
   output logic                           frame_ready,
   output logic                           busy,
   output logic                           done,
   output logic                           tx
);

   localparam int N_NIB = WORD_BITS / 4;
   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int NIB_W = (N_NIB > 1) ? $clog2(N_NIB) : 1;
   localparam int WRD_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
   localparam int IDX_W = $clog2(N_WORDS * WORD_BITS);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [NIB_W-1:0] NIB_TOP  = NIB_W'(N_NIB - 1);
   localparam logic [WRD_W-1:0] WRD_LAST = WRD_W'(N_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      C_NIB,
      C_SEP,
`ifdef HEX_FRAME_TX_LF_EN
      C_CR,
      C_LF
`else
      C_CR
`endif
   } sel_t;

   state_t                         state_q, state_d;
   sel_t                           sel_q;
   logic [DIV_W-1:0]               div_q;
   logic [2:0]                     bit_q;
   logic [NIB_W-1:0]               nib_q;
   logic [WRD_W-1:0]               wrd_q;
   logic [N_WORDS*WORD_BITS-1:0]   data_q;
   logic                           tx_q;

   logic                           accept;
   logic                           div_wrap;
   logic                           last_char;
   logic                           line_d;
   logic [IDX_W-1:0]               nib_base;
   logic [3:0]                     nibble;
   logic [7:0]                     hex_char;
   logic [7:0]                     cur_char;

   assign div_wrap = (div_q == DIV_LAST);
   assign accept   = frame_valid && frame_ready;
   assign tx       = tx_q;

`ifdef HEX_FRAME_TX_LF_EN
   assign last_char = (sel_q == C_LF);
`else
   assign last_char = (sel_q == C_CR);
`endif

   // Character currently being shifted out, chosen by the selector.
   always_comb begin
      nib_base = IDX_W'(int'(wrd_q) * WORD_BITS + int'(nib_q) * 4);
      nibble   = data_q[nib_base +: 4];
      hex_char = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                  : (8'h37 + {4'h0, nibble});
      cur_char = 8'h0D;
      case (sel_q)
         C_NIB:   cur_char = hex_char;
         C_SEP:   cur_char = SEP_CHAR;
         C_CR:    cur_char = 8'h0D;
`ifdef HEX_FRAME_TX_LF_EN
         C_LF:    cur_char = 8'h0A;
`endif
         default: cur_char = 8'h0D;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      frame_ready = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      line_d      = 1'b1;
      case (state_q)
         S_IDLE: begin
            frame_ready = 1'b1;
            if (accept) state_d = S_START;
         end
         S_START: begin
            busy   = 1'b1;
            line_d = 1'b0;
            if (div_wrap) state_d = S_DATA;
         end
         S_DATA: begin
            busy   = 1'b1;
            line_d = cur_char[bit_q];
            if (div_wrap && (bit_q == 3'd7)) state_d = S_STOP;
         end
         S_STOP: begin
            busy = 1'b1;
            if (div_wrap) state_d = last_char ? S_DONE : S_START;
         end
         S_DONE: begin
            // Ready again here so a waiting frame follows after a single idle clk.
            frame_ready = 1'b1;
            done        = 1'b1;
            state_d     = accept ? S_START : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // The line is registered, so tx trails the state register by one clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_q   <= 1'b1;
         div_q  <= '0;
         bit_q  <= '0;
         nib_q  <= '0;
         wrd_q  <= '0;
         sel_q  <= C_NIB;
         data_q <= '0;
      end else begin
         tx_q <= line_d;
         if (accept) begin
            data_q <= frame_data;
            sel_q  <= C_NIB;
            nib_q  <= NIB_TOP;
            wrd_q  <= '0;
            div_q  <= '0;
            bit_q  <= '0;
         end else if (busy) begin
            div_q <= div_wrap ? '0 : div_q + 1'b1;
            if (div_wrap && (state_q == S_DATA)) begin
               bit_q <= bit_q + 3'd1;
            end
            if (div_wrap && (state_q == S_STOP)) begin
               case (sel_q)
                  C_NIB: begin
                     if (nib_q == '0) begin
                        sel_q <= (wrd_q == WRD_LAST) ? C_CR : C_SEP;
                     end else begin
                        nib_q <= nib_q - 1'b1;
                     end
                  end
                  C_SEP: begin
                     sel_q <= C_NIB;
                     nib_q <= NIB_TOP;
                     wrd_q <= wrd_q + 1'b1;
                  end
`ifdef HEX_FRAME_TX_LF_EN
                  C_CR:    sel_q <= C_LF;
`endif
                  default: sel_q <= sel_q;
               endcase
            end
         end
      end
   end

endmodule
